// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: packs four accepted bytes little-endian into one
// 32-bit word. word_valid is combinational with the 4th byte so the parent
// can register the memory write in the following cycle.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int SHIFT_W = (BYTES_PER_WORD - 1) * BYTE_W;

  logic [1:0]         lane_q;
  logic [SHIFT_W-1:0] shift_q;

  assign word_valid = byte_valid && (lane_q == 2'd3);
  assign word_data  = {byte_data, shift_q};

  // Shift new bytes in from the top so the first byte ends up in bits [7:0].
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (abort) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (byte_valid) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {byte_data, shift_q[SHIFT_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader. Accepts a byte stream
//   count_lo, count_hi, payload (count words, little-endian)[, checksum]
// writes the words to consecutive addresses from 0 and holds the core until
// the image is complete.
// Optional feature: define INST_MEM_LOADER_CHECKSUM_EN to require a trailing
// byte equal to the XOR of all payload bytes.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CHK;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   cnt_lo_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_hdr;
  logic [CNT_W-1:0]    word_idx_q;
  logic                take;
  logic                data_take;
  logic                word_valid;
  logic [WORD_W-1:0]   word_data;
  logic                last_word;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   chk_q;
`endif

  assign take      = in_valid && in_ready;
  assign data_take = take && (state_q == S_DATA);
  assign count_hdr = {in_data, cnt_lo_q};
  assign last_word = word_valid && (word_idx_q == count_q - CNT_W'(1));

  loader_word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .abort      (state_q != S_DATA),
    .byte_valid (data_take),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CNT_LO;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CNT_LO: if (take) state_d = S_CNT_HI;
      S_CNT_HI: begin
        if (take) begin
          if (count_hdr > CNT_W'(DEPTH)) state_d = S_ERR;
          else if (count_hdr == '0)      state_d = AFTER_DATA;
          else                           state_d = S_DATA;
        end
      end
      S_DATA:   if (last_word) state_d = AFTER_DATA;
      S_CHK: begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        if (take) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
`else
        state_d = S_ERR;
`endif
      end
      S_DONE:   state_d = S_DONE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  // Header capture, word index and running payload checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      if (take && state_q == S_CNT_LO) cnt_lo_q <= in_data;
      if (take && state_q == S_CNT_HI) count_q  <= count_hdr;
      if (word_valid)                  word_idx_q <= word_idx_q + CNT_W'(1);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      if (data_take)                   chk_q <= chk_q ^ in_data;
`endif
    end
  end

  // Registered outputs: write strobe one cycle after the 4th byte, release
  // one cycle after reaching S_DONE so the final write lands first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      in_ready <= (state_d != S_DONE) && (state_d != S_ERR);
      mem_we   <= word_valid;
      if (word_valid) begin
        mem_addr  <= ADDR_W'(word_idx_q);
        mem_wdata <= word_data;
      end
      if (state_q == S_DONE) begin
        load_done <= 1'b1;
        core_hold <= 1'b0;
      end
      if (state_q == S_ERR) load_error <= 1'b1;
    end
  end

endmodule
